// File: rtl/alu_ctl_pkg.sv
// Shared unit selects, opcodes and sequencer state type for the ALU control slice.
package alu_ctl_pkg;

  // Unit select values placed in address[15:12].
  localparam logic [3:0] MainMemEn    = 4'd0;
  localparam logic [3:0] RegisterEn   = 4'd1;
  localparam logic [3:0] InstrMemEn   = 4'd2;
  localparam logic [3:0] MatrixAluEn  = 4'd3;
  localparam logic [3:0] IntegerAluEn = 4'd4;
  localparam logic [3:0] ExecuteEn    = 4'd5;

  localparam logic [7:0] IntAdd  = 8'h10;
  localparam logic [7:0] IntSub  = 8'h11;
  localparam logic [7:0] IntMult = 8'h12;
  localparam logic [7:0] IntDiv  = 8'h13;
  localparam logic [7:0] OpStop  = 8'hFF;

  typedef enum logic [4:0] {
    StIdle, StRd1, StCap1, StRd2, StCap2,
    StSetOp, StStbOp, StSetA, StStbA, StSetB, StStbB,
    StExec, StRdRes, StCapRes, StWb, StDone, StErr, StHalt
  } seq_state_t;

  // True for the opcodes that run through the full ALU sequence.
  function automatic logic is_int_op(input logic [7:0] op);
    return (op >= IntAdd) && (op <= IntDiv);
  endfunction

endpackage

// File: rtl/operand_addr_decode.sv
// Maps an 8-bit operand/destination field onto a bus address.
module operand_addr_decode
  import alu_ctl_pkg::*;
(
  input  logic [7:0]  field_i,
  output logic [15:0] addr_o
);

  // bit7 picks the register file (16 entries) or main memory (128 entries).
  always_comb begin
    if (field_i[7]) begin
      addr_o = {RegisterEn, 8'h00, field_i[3:0]};
    end else begin
      addr_o = {MainMemEn, 5'h00, field_i[6:0]};
    end
  end

endmodule

// File: rtl/int_alu_sequencer.sv
// Runs one integer instruction at a time: fetch operands, load and fire the ALU, write back.
module int_alu_sequencer
  import alu_ctl_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              halted,
  output logic [ADDR_W-1:0] address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] SeqDataOut,
  input  logic [DATA_W-1:0] BusDataIn,
  input  logic [DATA_W-1:0] IntAluDataOut,
  output logic              opcodeonBus,
  output logic              src1onBus,
  output logic              src2onBus
);

  localparam logic [15:0] AluAddr = {IntegerAluEn, 12'h000};

  seq_state_t        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              halt_seen_q;

  logic [7:0]  opcode;
  logic [15:0] src1_addr, src2_addr, dest_addr;

  assign opcode = instr_q[31:24];

  operand_addr_decode u_dec_src1 (.field_i(instr_q[15:8]),  .addr_o(src1_addr));
  operand_addr_decode u_dec_src2 (.field_i(instr_q[7:0]),   .addr_o(src2_addr));
  operand_addr_decode u_dec_dest (.field_i(instr_q[23:16]), .addr_o(dest_addr));

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      halt_seen_q <= (state_q == StHalt);
    end
  end

  // Next-state and operand/result capture.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          if (instr[31:24] == OpStop)        state_d = StHalt;
          else if (is_int_op(instr[31:24]))  state_d = StRd1;
          else                               state_d = StErr;
        end
      end
      StRd1:  state_d = StCap1;
      StCap1: begin
        op1_d   = BusDataIn;
        state_d = StRd2;
      end
      StRd2:  state_d = StCap2;
      StCap2: begin
        op2_d = BusDataIn;
        // Divide-by-zero is caught before the ALU is touched.
        if (opcode == IntDiv && BusDataIn == '0) state_d = StErr;
        else                                     state_d = StSetOp;
      end
      StSetOp:  state_d = StStbOp;
      StStbOp:  state_d = StSetA;
      StSetA:   state_d = StStbA;
      StStbA:   state_d = StSetB;
      StSetB:   state_d = StStbB;
      StStbB:   state_d = StExec;
      StExec:   state_d = StRdRes;
      StRdRes:  state_d = StCapRes;
      StCapRes: begin
        res_d   = IntAluDataOut;
        state_d = StWb;
      end
      StWb:     state_d = StDone;
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Bus and status outputs decoded from the current state; at most one strobe low per cycle.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    halted      = 1'b0;
    address     = '0;
    nRead       = 1'b1;
    nWrite      = 1'b1;
    SeqDataOut  = '0;
    opcodeonBus = 1'b1;
    src1onBus   = 1'b1;
    src2onBus   = 1'b1;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      StRd1: begin
        address = src1_addr;
        nRead   = 1'b0;
      end
      StCap1: address = src1_addr;
      StRd2: begin
        address = src2_addr;
        nRead   = 1'b0;
      end
      StCap2: address = src2_addr;
      StSetOp, StStbOp: begin
        address     = AluAddr;
        SeqDataOut  = {{(DATA_W-8){1'b0}}, opcode};
        opcodeonBus = (state_q != StStbOp);
      end
      StSetA, StStbA: begin
        address    = AluAddr;
        SeqDataOut = op1_q;
        src1onBus  = (state_q != StStbA);
      end
      StSetB, StStbB: begin
        address    = AluAddr;
        SeqDataOut = op2_q;
        src2onBus  = (state_q != StStbB);
      end
      StExec: begin
        address = AluAddr;
        nWrite  = 1'b0;
      end
      StRdRes: begin
        address = AluAddr;
        nRead   = 1'b0;
      end
      StCapRes: address = AluAddr;
      StWb: begin
        address    = dest_addr;
        SeqDataOut = res_q;
        nWrite     = 1'b0;
      end
      StDone: done = 1'b1;
      StErr: begin
        done = 1'b1;
        err  = 1'b1;
      end
      StHalt: begin
        busy   = 1'b0;
        halted = 1'b1;
        done   = !halt_seen_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_alu_sequencer.sv
// Self-checking bench: memory/register/ALU models around the sequencer, directed and random cases.
module tb_int_alu_sequencer;

  logic         Clk = 1'b0;
  logic         nReset;
  logic         instr_valid;
  logic [31:0]  instr;
  logic         instr_ready, busy, done, err, halted;
  logic [15:0]  address;
  logic         nRead, nWrite;
  logic [255:0] SeqDataOut, BusDataIn, IntAluDataOut;
  logic         opcodeonBus, src1onBus, src2onBus;

  always #5 Clk = ~Clk;

  int_alu_sequencer #(.DATA_W(256), .ADDR_W(16)) dut (
    .Clk(Clk), .nReset(nReset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .busy(busy), .done(done), .err(err), .halted(halted),
    .address(address), .nRead(nRead), .nWrite(nWrite), .SeqDataOut(SeqDataOut),
    .BusDataIn(BusDataIn), .IntAluDataOut(IntAluDataOut),
    .opcodeonBus(opcodeonBus), .src1onBus(src1onBus), .src2onBus(src2onBus)
  );

  // ALU arithmetic: 256-bit unsigned, wrapping.
  function automatic logic [255:0] alu_fn(input logic [7:0] op, input logic [255:0] a,
                                          input logic [255:0] b);
    case (op)
      8'h10:   return a + b;
      8'h11:   return a - b;
      8'h12:   return a * b;
      8'h13:   return (b == 0) ? 256'd0 : a / b;
      default: return 256'd0;
    endcase
  endfunction

  // Environment: memory, register file and ALU on the shared bus.
  logic [255:0] mem_m [128];
  logic [255:0] reg_m [16];
  logic [7:0]   alu_op;
  logic [255:0] alu_a, alu_b, alu_res;
  logic         pl_en, pl_reg;
  logic [6:0]   pl_idx;
  logic [255:0] pl_val;

  assign IntAluDataOut = alu_res;

  always @(posedge Clk) begin
    if (pl_en) begin
      if (pl_reg) reg_m[pl_idx[3:0]] <= pl_val;
      else        mem_m[pl_idx]      <= pl_val;
    end
    if (!nRead) begin
      if (address[15:12] == 4'd1)      BusDataIn <= reg_m[address[3:0]];
      else if (address[15:12] == 4'd0) BusDataIn <= mem_m[address[6:0]];
      else                             BusDataIn <= '0;
    end
    if (!nWrite) begin
      if (address[15:12] == 4'd0)      mem_m[address[6:0]] <= SeqDataOut;
      else if (address[15:12] == 4'd1) reg_m[address[3:0]] <= SeqDataOut;
      else if (address[15:12] == 4'd4) alu_res <= alu_fn(alu_op, alu_a, alu_b);
    end
    if (!opcodeonBus) alu_op <= SeqDataOut[7:0];
    if (!src1onBus)   alu_a  <= SeqDataOut;
    if (!src2onBus)   alu_b  <= SeqDataOut;
  end

  // Reference state, owned by the stimulus block.
  logic [255:0] ref_mem [128];
  logic [255:0] ref_reg [16];

  function automatic logic [255:0] ref_rd(input logic [7:0] f);
    return f[7] ? ref_reg[f[3:0]] : ref_mem[f[6:0]];
  endfunction

  function automatic logic [15:0] exp_addr(input logic [7:0] f);
    return f[7] ? (16'h1000 + {12'h000, f[3:0]}) : {9'h000, f[6:0]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] rfield();
    if ($urandom_range(0, 1) == 1)
      return {1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
    return {1'b0, 7'($urandom_range(0, 127))};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk_v(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] f, input logic [255:0] v);
    if (f[7]) ref_reg[f[3:0]] = v;
    else      ref_mem[f[6:0]] = v;
    pl_en  = 1'b1;
    pl_reg = f[7];
    pl_idx = f[6:0];
    pl_val = v;
    @(posedge Clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk_v({tag, "/ctl"},
          256'({instr_ready, busy, done, err, halted, nRead, nWrite,
                opcodeonBus, src1onBus, src2onBus}), 256'(10'b1000011111));
    chk_v({tag, "/addr"}, 256'(address), 256'd0);
    chk_v({tag, "/wdata"}, SeqDataOut, 256'd0);
  endtask

  // Per-instruction observations, cycle numbers counted from the accept edge.
  int done_cyc, wr_cyc, op_cyc, a_cyc, b_cyc, wr_cnt;
  int multi_low, rd_low, wl_low, nz_addr, err_seen, rdy_next, busy1;
  logic [15:0]  wr_addr;
  logic [255:0] wr_data, op_data, a_data, b_data;

  task automatic run(input logic [31:0] ins, input int abort_at);
    int n;
    done_cyc = -1; wr_cyc = -1; op_cyc = -1; a_cyc = -1; b_cyc = -1; wr_cnt = 0;
    multi_low = 0; rd_low = 0; wl_low = 0; nz_addr = 0;
    err_seen = -1; rdy_next = -1; busy1 = -1;
    @(negedge Clk);
    instr = ins;
    instr_valid = 1'b1;
    chk_i("ready_before", int'(instr_ready), 1);
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 1) busy1 = int'(busy);
      n = 0;
      if (!nRead) n++;
      if (!nWrite) n++;
      if (!opcodeonBus) n++;
      if (!src1onBus) n++;
      if (!src2onBus) n++;
      if (n > 1) multi_low++;
      if (!nRead) rd_low++;
      if (!nWrite || !opcodeonBus || !src1onBus || !src2onBus) wl_low++;
      if (address != 16'h0) nz_addr++;
      if (!nWrite && address[15:12] != 4'd4) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_addr = address;
        wr_data = SeqDataOut;
      end
      if (!opcodeonBus) begin op_cyc = c; op_data = SeqDataOut; end
      if (!src1onBus)   begin a_cyc  = c; a_data  = SeqDataOut; end
      if (!src2onBus)   begin b_cyc  = c; b_data  = SeqDataOut; end
      if (c == abort_at) begin
        nReset = 1'b0;
        @(negedge Clk);
        check_idle("abort");
        nReset = 1'b1;
        break;
      end
      if (done) begin
        done_cyc = c;
        err_seen = int'(err);
        @(negedge Clk);
        rdy_next = int'(instr_ready);
        break;
      end
    end
  endtask

  task automatic check_normal(input string tag, input logic [7:0] op, input logic [255:0] a,
                              input logic [255:0] b, input logic [7:0] d);
    chk_i({tag, "/done_cyc"}, done_cyc, 15);
    chk_i({tag, "/err"}, err_seen, 0);
    chk_i({tag, "/busy"}, busy1, 1);
    chk_i({tag, "/op_cyc"}, op_cyc, 6);
    chk_i({tag, "/a_cyc"}, a_cyc, 8);
    chk_i({tag, "/b_cyc"}, b_cyc, 10);
    chk_v({tag, "/op_data"}, op_data, {248'h0, op});
    chk_v({tag, "/a_data"}, a_data, a);
    chk_v({tag, "/b_data"}, b_data, b);
    chk_i({tag, "/wr_cyc"}, wr_cyc, 14);
    chk_i({tag, "/wr_cnt"}, wr_cnt, 1);
    chk_v({tag, "/wr_addr"}, 256'(wr_addr), 256'(exp_addr(d)));
    chk_v({tag, "/wr_data"}, wr_data, alu_fn(op, a, b));
    chk_i({tag, "/one_low"}, multi_low, 0);
    chk_i({tag, "/ready16"}, rdy_next, 1);
    if (d[7]) ref_reg[d[3:0]] = alu_fn(op, a, b);
    else      ref_mem[d[6:0]] = alu_fn(op, a, b);
  endtask

  initial begin
    logic [7:0]   op, s1, s2, d;
    logic [255:0] va, vb;
    int           bad;
    nReset = 1'b0; instr_valid = 1'b0; instr = '0;
    pl_en = 1'b0; pl_reg = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle("reset");
    nReset = 1'b1;

    // IntAdd R1 + R2 -> R3
    preload(8'h81, 256'd5);
    preload(8'h82, 256'd7);
    run(32'h10838182, 0);
    check_normal("add", 8'h10, 256'd5, 256'd7, 8'h83);

    // IntSub M[5] - M[4] -> M[6]
    preload(8'h04, 256'd3);
    preload(8'h05, 256'd10);
    run(32'h11060504, 0);
    check_normal("sub", 8'h11, 256'd10, 256'd3, 8'h06);
    chk_v("sub/mem6", mem_m[6], 256'd7);

    // Divide by zero
    preload(8'h82, 256'd0);
    run(32'h13818182, 0);
    chk_i("div0/done_cyc", done_cyc, 5);
    chk_i("div0/err", err_seen, 1);
    chk_i("div0/no_wr_or_load", wl_low, 0);

    // Unknown opcode
    run(32'h20818283, 0);
    chk_i("badop/done_cyc", done_cyc, 1);
    chk_i("badop/err", err_seen, 1);
    chk_i("badop/no_read", rd_low, 0);
    chk_i("badop/no_wr_or_load", wl_low, 0);
    chk_i("badop/addr_idle", nz_addr, 0);
    chk_i("badop/ready2", rdy_next, 1);

    // Random legal instructions against the reference state
    for (int k = 0; k < 6; k++) begin
      op = 8'h10 + 8'($urandom_range(0, 3));
      s1 = rfield();
      s2 = rfield();
      d  = rfield();
      preload(s1, rand256());
      preload(s2, (op == 8'h13) ? 256'($urandom_range(1, 1000)) : rand256());
      va = ref_rd(s1);
      vb = ref_rd(s2);
      if (op == 8'h13 && vb == 0) op = 8'h10;
      run({op, d, s1, s2}, 0);
      check_normal($sformatf("rand%0d", k), op, va, vb, d);
    end

    // IntMult aborted by reset in cycle 9, then a normal IntAdd
    preload(8'h83, 256'd99);
    preload(8'h81, 256'd6);
    preload(8'h82, 256'd9);
    run(32'h12838182, 9);
    chk_i("abort/wr_cnt", wr_cnt, 0);
    repeat (20) @(negedge Clk);
    chk_v("abort/r3_kept", reg_m[3], 256'd99);
    run(32'h10838182, 0);
    check_normal("after_abort", 8'h10, 256'd6, 256'd9, 8'h83);

    // Stop: sticky halt until reset
    run(32'hFF000000, 0);
    chk_i("halt/done_cyc", done_cyc, 1);
    chk_i("halt/err", err_seen, 0);
    chk_i("halt/ready2", rdy_next, 0);
    instr = 32'h10838182;
    instr_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge Clk);
      if (!halted || instr_ready || busy || done || !nWrite || !nRead) bad++;
    end
    chk_i("halt/hold50", bad, 0);
    instr_valid = 1'b0;
    nReset = 1'b0;
    @(negedge Clk);
    check_idle("halt_reset");
    nReset = 1'b1;
    run(32'h10838182, 0);
    check_normal("after_halt", 8'h10, 256'd6, 256'd9, 8'h83);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
